// File: rtl/rgbled_wrq.sv
// rgbled_wrq: LED write queue between the 6502 bus and the LEDDA register port.
// CPU writes are captured into a DEPTH-entry FIFO without stalling and replayed
// to the LED driver as single-cycle led_we strobes separated by GAP low cycles.
// Optional feature macro: RGBLED_STATUS_EN (status readback on dbr plus the
// sticky overflow flag). Without it dbr is tied to 8'h00 and no ovf register
// exists; entries written while full are still dropped.
module rgbled_wrq #(
  parameter int DEPTH = 4,   // FIFO entries, power of two, 2..16
  parameter int GAP   = 2    // low cycles between led_we strobes, 0..255
) (
  input  logic       clk,
  input  logic       rst,      // asynchronous, active-low
  input  logic       cs,
  input  logic       we,
  input  logic [3:0] addr,
  input  logic [7:0] dbw,
  output logic [7:0] dbr,
  output logic       led_we,
  output logic [3:0] led_addr,
  output logic [7:0] led_dbw
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam bit        GAP_ZERO = (GAP == 0);
  localparam logic [7:0] GAP_M1  = (GAP == 0) ? 8'd0 : 8'(GAP - 1);

  // Drain FSM encoding
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] STROBE = 2'd1;
  localparam logic [1:0] HOLD   = 2'd2;

  logic [11:0]   mem [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [CW-1:0] count;
  logic [1:0]    state;
  logic [7:0]    gap_cnt;

  logic full;
  logic empty;
  logic push_req;
  logic push;
  logic pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign push_req = cs & we;
  // A pop on the same edge frees a slot, so a push at full is still accepted.
  assign push     = push_req & (~full | pop);

  // Decide whether the drain FSM takes the head entry this cycle.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    pop = 1'b0;
    case (state)
      IDLE:    pop = ~empty;
      STROBE:  pop = GAP_ZERO & ~empty;
      HOLD:    pop = (gap_cnt == 8'd0) & ~empty;
      default: pop = 1'b0;
    endcase
  end

  // FIFO storage write; entries are only ever read after being written.
  // NOTE: the storage array is deliberately not reset; count/pointers define validity.
  always_ff @(posedge clk) begin
    if (push) mem[tail] <= {addr, dbw};
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH (power of two).
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + AW'(1);
      if (pop)  head <= head + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Drain FSM: strobe the head entry to the LED port, then wait GAP cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      led_we   <= 1'b0;
      led_addr <= 4'h0;
      led_dbw  <= 8'h00;
      gap_cnt  <= 8'd0;
    end else begin
      if (pop) {led_addr, led_dbw} <= mem[head];
      case (state)
        IDLE: begin
          if (pop) begin
            led_we <= 1'b1;
            state  <= STROBE;
          end
        end
        STROBE: begin
          if (GAP_ZERO) begin
            if (pop) begin
              led_we <= 1'b1;
            end else begin
              led_we <= 1'b0;
              state  <= IDLE;
            end
          end else begin
            led_we  <= 1'b0;
            gap_cnt <= GAP_M1;
            state   <= HOLD;
          end
        end
        HOLD: begin
          if (gap_cnt != 8'd0) begin
            gap_cnt <= gap_cnt - 8'd1;
          end else if (pop) begin
            led_we <= 1'b1;
            state  <= STROBE;
          end else begin
            state  <= IDLE;
          end
        end
        default: begin
          led_we <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

`ifdef RGBLED_STATUS_EN
  logic       ovf;
  logic       busy;
  logic       rd;
  logic [4:0] count5;

  assign rd     = cs & ~we;
  assign busy   = (state != IDLE) | ~empty;
  assign count5 = 5'(count);

  // Sticky overflow: set by a dropped write, cleared by a status read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf <= 1'b0;
    end else if (push_req & full & ~pop) begin
      ovf <= 1'b1;
    end else if (rd) begin
      ovf <= 1'b0;
    end
  end

  // Status readback, valid in the same cycle as the read; zero otherwise.
  always_comb begin
    dbr = 8'h00;
    if (rd) dbr = {busy, ovf, full, count5};
  end
`else
  assign dbr = 8'h00;
`endif

endmodule

// File: tb/tb_rgbled_wrq.sv
// tb_rgbled_wrq: directed scoreboard bench for rgbled_wrq. Two instances share
// the bus (separate chip selects): one with GAP=2, one with GAP=0. Expected
// strobes (address, data, edge number) are queued as stimulus is issued and a
// monitor pops and compares on every cycle where led_we is high.
module tb_rgbled_wrq;

  typedef struct {
    logic [3:0] a;
    logic [7:0] d;
    int         e;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       cs2;
  logic       cs0;
  logic       we;
  logic [3:0] addr;
  logic [7:0] dbw;

  logic [7:0] dbr2, dbr0;
  logic       led_we2, led_we0;
  logic [3:0] led_addr2, led_addr0;
  logic [7:0] led_dbw2, led_dbw0;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  exp_t q2[$];
  exp_t q0[$];
  exp_t m2;
  exp_t m0;

  rgbled_wrq #(.DEPTH(4), .GAP(2)) u_dut2 (
    .clk(clk), .rst(rst), .cs(cs2), .we(we), .addr(addr), .dbw(dbw),
    .dbr(dbr2), .led_we(led_we2), .led_addr(led_addr2), .led_dbw(led_dbw2)
  );

  rgbled_wrq #(.DEPTH(4), .GAP(0)) u_dut0 (
    .clk(clk), .rst(rst), .cs(cs0), .we(we), .addr(addr), .dbw(dbw),
    .dbr(dbr0), .led_we(led_we0), .led_addr(led_addr0), .led_dbw(led_dbw0)
  );

  always #5 clk = ~clk;

  // Edge counter: at the following negedge, cyc is the index of the last edge.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (edge %0d)", name, got, want, cyc);
    end
  endtask

  // Expected status value: status bits exist only with the feature enabled.
  function automatic logic [7:0] st(input logic [7:0] v);
`ifdef RGBLED_STATUS_EN
    return v;
`else
    return 8'h00;
`endif
  endfunction

  // Apply one bus cycle; the next posedge (edge cyc+1) samples it.
  task automatic drive(input logic c2, input logic c0, input logic w,
                       input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    cs2 = c2; cs0 = c0; we = w; addr = a; dbw = d;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
  endtask

  // Write to the GAP=2 instance; off<0 means the entry is expected to be dropped.
  task automatic write2(input logic [3:0] a, input logic [7:0] d, input int off);
    exp_t e;
    drive(1'b1, 1'b0, 1'b1, a, d);
    if (off >= 0) begin
      e.a = a; e.d = d; e.e = cyc + 1 + off;
      q2.push_back(e);
    end
  endtask

  task automatic write0(input logic [3:0] a, input logic [7:0] d, input int off);
    exp_t e;
    drive(1'b0, 1'b1, 1'b1, a, d);
    e.a = a; e.d = d; e.e = cyc + 1 + off;
    q0.push_back(e);
  endtask

  task automatic read(input logic sel2, input logic [7:0] want, input string name);
    drive(sel2, ~sel2, 1'b0, 4'h0, 8'h00);
    #1;
    if (sel2) check(name, dbr2, st(want));
    else      check(name, dbr0, st(want));
  endtask

  // Monitor for the GAP=2 instance.
  always @(negedge clk) begin
    if (led_we2 === 1'b1) begin
      if (q2.size() == 0) begin
        total++; bad++;
        $display("FAIL strobe2_unexpected: got addr=%0h data=%0h want none (edge %0d)",
                 led_addr2, led_dbw2, cyc);
      end else begin
        m2 = q2.pop_front();
        check("strobe2_edge", cyc, m2.e);
        check("strobe2_addr", led_addr2, m2.a);
        check("strobe2_data", led_dbw2, m2.d);
      end
    end
  end

  // Monitor for the GAP=0 instance.
  always @(negedge clk) begin
    if (led_we0 === 1'b1) begin
      if (q0.size() == 0) begin
        total++; bad++;
        $display("FAIL strobe0_unexpected: got addr=%0h data=%0h want none (edge %0d)",
                 led_addr0, led_dbw0, cyc);
      end else begin
        m0 = q0.pop_front();
        check("strobe0_edge", cyc, m0.e);
        check("strobe0_addr", led_addr0, m0.a);
        check("strobe0_data", led_dbw0, m0.d);
      end
    end
  end

  // Hard bound on run time.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Power-on: hold reset with random bus traffic.
    rst = 1'b1; cs2 = 1'b0; cs0 = 1'b0; we = 1'b0; addr = 4'h0; dbw = 8'h00;
    #1 rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            4'($urandom), 8'($urandom));
      #1;
      check("rst_led_we", {led_we2, led_we0}, 2'b00);
      check("rst_led_addr", {led_addr2, led_addr0}, 8'h00);
      check("rst_led_dbw", {led_dbw2, led_dbw0}, 16'h0000);
      check("rst_dbr", {dbr2, dbr0}, 16'h0000);
    end
    @(negedge clk);
    rst = 1'b1; cs2 = 1'b0; cs0 = 1'b0;
    read(1'b1, 8'h00, "post_rst_dbr");

    // Single write, GAP=2: one strobe on E1, idle afterwards.
    write2(4'h8, 8'hA5, 1);
    idle(8);
    read(1'b1, 8'h00, "single_status");

    // Burst of 8 into DEPTH=4, GAP=2: entry 16 (E6) dropped.
    begin
      int offs [8];
      offs = '{1, 3, 5, 7, 9, 11, -1, 12};
      // Offsets above are relative to each write's own edge Ei = E0+i:
      // strobes land at E1,E4,E7,E10,E13,E16,E19.
      for (int i = 0; i < 8; i++) write2(4'h3, 8'h10 + 8'(i), offs[i]);
    end
    read(1'b1, 8'hE4, "burst_status_ovf");
    read(1'b1, 8'hA4, "burst_status_clr");
    idle(20);
    read(1'b1, 8'h00, "burst_drained");

    // GAP=0: three writes give back-to-back strobes on E1..E3.
    write0(4'h5, 8'h31, 1);
    write0(4'h5, 8'h32, 1);
    write0(4'h5, 8'h33, 1);
    idle(5);
    read(1'b0, 8'h00, "gap0_idle");

    // Reset pulse in HOLD with three entries queued.
    write2(4'h7, 8'h41, 1);
    write2(4'h7, 8'h42, -1);
    write2(4'h7, 8'h43, -1);
    write2(4'h7, 8'h44, -1);
    @(negedge clk);
    rst = 1'b0; cs2 = 1'b0; cs0 = 1'b0; we = 1'b0;
    #1;
    check("midrst_led_addr", led_addr2, 4'h0);
    check("midrst_led_dbw", led_dbw2, 8'h00);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    idle(6);
    read(1'b1, 8'h00, "midrst_status");
    write2(4'h9, 8'h5A, 1);
    idle(6);

    check("q2_drained", q2.size(), 0);
    check("q0_drained", q0.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
